sr_uart_tx_drain: RTL

- Downstream consumer of the core's output FIFO.
- Pops one word at a time from the FIFO read port and serialises the low BYTES_PER_WORD bytes, least-significant byte first, as 8N1 UART frames on a single tx line.
- Gives the CPU a memory-mapped console/debug output path with back-pressure provided by the FIFO's full flag.

---
 rtl/sr_uart_pkg.sv | 24 ++
 rtl/sr_uart_bit_timer.sv | 36 +++
 rtl/sr_uart_tx_drain.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sr_uart_pkg.sv
// Shared definitions for the UART transmit drain: FSM state encoding,
// 8N1 frame constants and a counter-width helper.
package sr_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int timer_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_uart_bit_timer.sv
// Free-running bit-period counter; tick marks the last cycle of each period.
module sr_uart_bit_timer
  import sr_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CNT_W = timer_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg + 1'b1;
    if (clear || (count_reg == LAST)) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/sr_uart_tx_drain.sv
// Pops words from the output FIFO and sends their low bytes, LSB byte first,
// as 8N1 UART frames on tx. All outputs decode from registered state only.
module sr_uart_tx_drain
  import sr_uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CLKS_PER_BIT   = 16,
  parameter int BYTES_PER_WORD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_push,
  output logic                  fifo_read_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_done
);

  localparam int SHIFT_W = DATA_BITS * BYTES_PER_WORD;
  localparam int BYTE_W  = timer_width(BYTES_PER_WORD);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_WORD - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  state_t              state_reg, state_next;
  logic [2:0]          bit_idx_reg, bit_idx_next;
  logic [BYTE_W-1:0]   byte_idx_reg, byte_idx_next;
  logic [SHIFT_W-1:0]  shift_reg, shift_next;
  logic                tick;
  logic                timer_clear;

  // Word bits above the transmitted bytes are intentionally dropped.
  if (SHIFT_W < DATA_WIDTH) begin : g_discard
    logic unused_upper;
    assign unused_upper = ^fifo_read_data[DATA_WIDTH-1:SHIFT_W];
  end

  // The timer restarts on every state entry so each bit period is full length.
  assign timer_clear = (state_reg inside {ST_IDLE, ST_POP, ST_LATCH}) ||
                       (state_next != state_reg);

  sr_uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .tick (tick)
  );

  always_comb begin
    state_next    = state_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    shift_next    = shift_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_POP;
      end
      // A pop colliding with a push is dropped by the FIFO, so retry later.
      ST_POP: begin
        state_next = fifo_push ? ST_IDLE : ST_LATCH;
      end
      ST_LATCH: begin
        shift_next    = fifo_read_data[SHIFT_W-1:0];
        byte_idx_next = '0;
        state_next    = ST_START;
      end
      ST_START: begin
        if (tick) begin
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next   = shift_reg >> 1;
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == LAST_BIT) state_next = ST_STOP;
        end
      end
      // After eight shifts the next byte of the word already sits in bit 0.
      ST_STOP: begin
        if (tick) begin
          if (byte_idx_reg < LAST_BYTE) begin
            byte_idx_next = byte_idx_reg + 1'b1;
            state_next    = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      shift_reg    <= shift_next;
    end
  end

  always_comb begin
    tx = IDLE_LEVEL;
    case (state_reg)
      ST_START: tx = START_LEVEL;
      ST_DATA:  tx = shift_reg[0];
      ST_STOP:  tx = STOP_LEVEL;
      default:  tx = IDLE_LEVEL;
    endcase
  end

  assign fifo_read_enable = (state_reg == ST_POP);
  assign busy             = (state_reg != ST_IDLE);
  assign byte_done        = (state_reg == ST_STOP) && tick;

endmodule
